// File: rtl/output_stream_buffer_if.sv
// Pixel stream bundle between the convolution controller, the output buffer and the host.
// The slave view is the buffer itself; the master view is whatever drives and drains it.
interface output_stream_buffer_if #(
  parameter int ACCUMULATION_WIDTH = 32
);
  logic                          in_valid;
  logic                          in_last;
  logic [ACCUMULATION_WIDTH-1:0] in_data;
  logic [31:0]                   in_x;
  logic [31:0]                   in_y;
  logic [31:0]                   in_ch;
  logic                          almost_full;

  logic                          out_valid;
  logic                          out_ready;
  logic [ACCUMULATION_WIDTH-1:0] out_data;
  logic [31:0]                   out_x;
  logic [31:0]                   out_y;
  logic [31:0]                   out_ch;
  logic                          out_last;

  modport slave (
    input  in_valid, in_last, in_data, in_x, in_y, in_ch, out_ready,
    output almost_full, out_valid, out_data, out_x, out_y, out_ch, out_last
  );

  modport master (
    output in_valid, in_last, in_data, in_x, in_y, in_ch, out_ready,
    input  almost_full, out_valid, out_data, out_x, out_y, out_ch, out_last
  );
endinterface

// File: rtl/output_stream_buffer.sv
// Captures finished output pixels into a small FWFT FIFO, streams them to the host and
// pulses layer_done once the final pixel of a layer has been consumed.
module output_stream_buffer #(
  parameter int ACCUMULATION_WIDTH = 32,
  parameter int FIFO_DEPTH         = 4,
  parameter int ALMOST_FULL_MARGIN = 2
) (
  input  logic                        clk,
  input  logic                        arst_n_in,
  input  logic                        start,
  output_stream_buffer_if.slave       s,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overflow,
  output logic                        layer_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_THRESH = CW'(FIFO_DEPTH - ALMOST_FULL_MARGIN);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic                          last;
    logic [31:0]                   ch;
    logic [31:0]                   y;
    logic [31:0]                   x;
    logic [ACCUMULATION_WIDTH-1:0] data;
  } entry_t;

  state_t        state;
  entry_t        mem [FIFO_DEPTH];
  entry_t        head;
  entry_t        wr_entry;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_nxt;
  logic          full, push, pop, drop;

  assign full        = (count == DEPTH_C);
  assign s.out_valid = (count != '0);
  assign pop         = s.out_valid && s.out_ready;
  assign push        = s.in_valid && (state == ACTIVE) && (!full || pop);
  // A full FIFO with no pop in the same cycle cannot take the pixel; it is lost.
  assign drop        = s.in_valid && (state == ACTIVE) && full && !pop;
  assign count_nxt   = count + CW'(push) - CW'(pop);

  assign wr_entry = '{last: s.in_last, ch: s.in_ch, y: s.in_y, x: s.in_x, data: s.in_data};
  assign head     = mem[rd_ptr];

  // Head is gated so an empty FIFO presents all-zero outputs.
  assign s.out_data = s.out_valid ? head.data : '0;
  assign s.out_x    = s.out_valid ? head.x    : '0;
  assign s.out_y    = s.out_valid ? head.y    : '0;
  assign s.out_ch   = s.out_valid ? head.ch   : '0;
  assign s.out_last = s.out_valid && head.last;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      overflow      <= 1'b0;
      layer_done    <= 1'b0;
      s.almost_full <= 1'b0;
    end else begin
      layer_done <= 1'b0;
      if (state == IDLE && start) begin
        state         <= ACTIVE;
        wr_ptr        <= '0;
        rd_ptr        <= '0;
        count         <= '0;
        overflow      <= 1'b0;
        s.almost_full <= (AF_THRESH == '0);
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (drop) overflow <= 1'b1;
        count         <= count_nxt;
        s.almost_full <= (count_nxt >= AF_THRESH);
        case (state)
          ACTIVE: if (push && s.in_last) state <= DRAIN;
          DRAIN: begin
            if (count == '0) begin
              state      <= DONE;
              layer_done <= 1'b1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
